// File: rtl/pc_gen.sv
// Front-of-pipeline PC generator: architectural fetch PC, gshare direction
// predictor (PHT + committed GHR) and a direct-mapped BTB for taken targets.
module pc_gen #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    GHR_WIDTH       = 5,
  parameter int                    BTB_INDEX_WIDTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = 32'hBFC00000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_pc,
  input  logic                  stall,
  input  logic                  update_valid,
  input  logic                  update_is_branch,
  input  logic                  update_taken,
  input  logic [ADDR_WIDTH-1:0] update_pc,
  input  logic [GHR_WIDTH-1:0]  update_pht_index,
  input  logic [ADDR_WIDTH-1:0] update_target,
  output logic                  is_branch_taken_out,
  output logic [GHR_WIDTH-1:0]  pht_index_out,
  output logic [ADDR_WIDTH-1:0] pc_out
);

  localparam int PHT_DEPTH = 1 << GHR_WIDTH;
  localparam int BTB_DEPTH = 1 << BTB_INDEX_WIDTH;
  localparam int TAG_WIDTH = ADDR_WIDTH - BTB_INDEX_WIDTH - 2;

  // Interface contract: update_valid is a single-cycle strobe with no ready
  // (training is always accepted); stall only freezes the PC, never training.

  logic [ADDR_WIDTH-1:0]      pc_q;
  logic [ADDR_WIDTH-1:0]      pc_d;
  logic [GHR_WIDTH-1:0]       ghr_q;
  logic [1:0]                 pht_q [PHT_DEPTH];
  logic [BTB_DEPTH-1:0]       btb_valid_q;
  logic [TAG_WIDTH-1:0]       btb_tag_q [BTB_DEPTH];
  logic [ADDR_WIDTH-1:0]      btb_target_q [BTB_DEPTH];

  logic [BTB_INDEX_WIDTH-1:0] btb_index;
  logic [TAG_WIDTH-1:0]       pc_tag;
  logic                       btb_hit;
  logic [BTB_INDEX_WIDTH-1:0] upd_btb_index;
  logic [TAG_WIDTH-1:0]       upd_tag;
  logic                       train;
  logic [1:0]                 upd_ctr;

  assign btb_index     = pc_q[BTB_INDEX_WIDTH+1:2];
  assign pc_tag        = pc_q[ADDR_WIDTH-1:BTB_INDEX_WIDTH+2];
  assign upd_btb_index = update_pc[BTB_INDEX_WIDTH+1:2];
  assign upd_tag       = update_pc[ADDR_WIDTH-1:BTB_INDEX_WIDTH+2];
  assign train         = update_valid && update_is_branch;

  // Prediction reads pre-update state only; same-cycle writes land next cycle.
  assign pht_index_out       = pc_q[GHR_WIDTH+1:2] ^ ghr_q;
  assign btb_hit             = btb_valid_q[btb_index] && (btb_tag_q[btb_index] == pc_tag);
  assign is_branch_taken_out = btb_hit && pht_q[pht_index_out][1];
  assign pc_out              = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (flush) begin
      pc_d = flush_pc;
    end else if (!stall) begin
      pc_d = is_branch_taken_out ? btb_target_q[btb_index] : pc_q + ADDR_WIDTH'(4);
    end
  end

  always_comb begin
    upd_ctr = pht_q[update_pht_index];
    if (update_taken) begin
      if (upd_ctr != 2'b11) upd_ctr = upd_ctr + 2'b01;
    end else begin
      if (upd_ctr != 2'b00) upd_ctr = upd_ctr - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      ghr_q       <= '0;
      btb_valid_q <= '0;
      for (int i = 0; i < PHT_DEPTH; i++) pht_q[i] <= 2'b01;
    end else begin
      pc_q <= pc_d;
      if (train) begin
        ghr_q                    <= {ghr_q[GHR_WIDTH-2:0], update_taken};
        pht_q[update_pht_index]  <= upd_ctr;
        if (update_taken) btb_valid_q[upd_btb_index] <= 1'b1;
      end
    end
  end

  // Tag/target payload needs no reset: it is qualified by btb_valid_q.
  always_ff @(posedge clk) begin
    if (!rst && train && update_taken) begin
      btb_tag_q[upd_btb_index]    <= upd_tag;
      btb_target_q[upd_btb_index] <= update_target;
    end
  end

endmodule
